aes_round_controller: RTL and testbench
=======================================

Name: aes_round_controller

Overview:
- Sequences one AES block encryption through the shared round datapath: state load, initial AddRoundKey, NUM_ROUNDS rounds of SubBytes/ShiftRows/MixColumns/AddRoundKey, with MixColumns skipped in the final round.
- Sits between the USB packet-side block requester (start/done handshake) and the round datapath and key schedule.
- Owns the round count.
- Waits on the key schedule for each round key before issuing AddRoundKey.

Parameters:
- NUM_ROUNDS, 10, number of full rounds (AES-128). Legal range 2..15.
- ROUND_W, 4, width of round_num and key_round. Must satisfy 2**ROUND_W > NUM_ROUNDS.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- n_rst  input  1  asynchronous active-low reset.
- start  input  1  request to encrypt the block currently presented to the datapath; sampled only in IDLE.
- abort  input  1  cancel the operation in progress.
- key_ready  input  1  key schedule has the round key for key_round available (level).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the ciphertext is valid in the datapath.
- load_state  output  1  datapath captures plaintext this cycle.
- do_sub  output  1  datapath applies SubBytes this cycle.
- do_shift  output  1  datapath applies ShiftRows this cycle.
- do_mix  output  1  datapath applies MixColumns this cycle.
- do_ark  output  1  datapath applies AddRoundKey this cycle.
- key_req  output  1  request round key key_round from the key schedule (level).
- key_round  output  ROUND_W  index of the requested round key.
- round_num  output  ROUND_W  current round, 0..NUM_ROUNDS.

Behaviour:
- States: IDLE, LOAD, SUB, SHIFT, MIX, ARK, DONE.
- Moore outputs, with one exception: do_ark is qualified by key_ready.
- Reset (asynchronous, any state):
  - State goes to IDLE, round_num=0.
  - All outputs 0, key_round=0.
- IDLE:
  - start=1 and abort=0 -> LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - load_state=1, round_num=0.
  - Next state ARK.
- ARK:
  - key_req=1, key_round=round_num.
  - key_ready=0: stay in ARK. No datapath strobe; stalls are unbounded.
  - key_ready=1: do_ark=1 in the same cycle, then:
    - round_num==NUM_ROUNDS -> DONE.
    - Otherwise round_num increments and the state goes to SUB.
- SUB: do_sub=1, then SHIFT.
- SHIFT: do_shift=1, then:
  - round_num==NUM_ROUNDS -> ARK (final round, MixColumns skipped).
  - Otherwise -> MIX.
- MIX: do_mix=1, then ARK.
- DONE:
  - done=1 for exactly one cycle, busy=1, then IDLE.
  - round_num resets to 0 on the DONE->IDLE transition.
- Exactly one of load_state/do_sub/do_shift/do_mix/do_ark is high in any cycle; none is high in IDLE, DONE, or an ARK stall.
- round_num increments only on ARK->SUB. It never exceeds NUM_ROUNDS and never wraps.
- Latency with key_ready held at 1:
  - Start accepted at edge 0 -> LOAD in cycle 1.
  - Final ARK in cycle 2+4*(NUM_ROUNDS-1)+3.
  - done in the next cycle, which is cycle 42 for NUM_ROUNDS=10.
  - Each stalled ARK cycle adds one cycle.
- start while busy=1 (including DONE) is ignored and is not queued.
- abort:
  - In any non-IDLE state, the next state is IDLE with round_num=0.
  - No done pulse.
  - Abort has priority over key_ready and over all transitions.
  - In the abort cycle, outputs still reflect the current state.
  - In IDLE, abort has priority over start: start is ignored.
- Reset mid-operation behaves the same as abort, but takes effect asynchronously.

Test Plan:
- Reset then idle: hold n_rst=0, then release with start=0 for 5 cycles -> busy=0, all strobes 0, round_num=0, key_req=0.
- Nominal run, key_ready=1 constant: pulse start -> load_state in cycle 1; do_ark with key_round=0 in cycle 2; round 1 sub/shift/mix/ark in cycles 3-6; round 10 is sub, shift, ark only (no do_mix); done single pulse in cycle 42; exactly 9 do_mix pulses and 11 do_ark pulses.
- Key stall: hold key_ready=0 for 3 cycles at the round-4 ARK -> key_req=1 with key_round=4 throughout the stall, no strobes during the stall, done delayed to cycle 45.
- Abort mid-round: assert abort during MIX of round 6 -> IDLE next cycle, busy=0, round_num=0, no done. A subsequent start runs a complete 42-cycle encryption.
- Start collisions: start held high during the whole run and in the DONE cycle -> only one encryption and one done pulse. start and abort together in IDLE -> stays IDLE.
- Async reset mid-run: drop n_rst during round 3 SUB, between clock edges -> outputs and round_num are 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/aes_round_controller.sv
// Round sequencer for one AES block: load, initial AddRoundKey, then NUM_ROUNDS
// rounds of Sub/Shift/(Mix)/ARK, stalling in ARK until the key schedule is ready.
module aes_round_controller #(
    parameter int NUM_ROUNDS = 10,
    parameter int ROUND_W    = 4
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic               abort,
    input  logic               key_ready,
    output logic               busy,
    output logic               done,
    output logic               load_state,
    output logic               do_sub,
    output logic               do_shift,
    output logic               do_mix,
    output logic               do_ark,
    output logic               key_req,
    output logic [ROUND_W-1:0] key_round,
    output logic [ROUND_W-1:0] round_num
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SUB   = 3'd2,
        SHIFT = 3'd3,
        MIX   = 3'd4,
        ARK   = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);
    localparam logic [ROUND_W-1:0] ROUND_ZERO = {ROUND_W{1'b0}};
    localparam logic [ROUND_W-1:0] ROUND_ONE  = {{(ROUND_W-1){1'b0}}, 1'b1};

    state_t             state_q;
    state_t             state_d;
    logic [ROUND_W-1:0] round_num_q;
    logic [ROUND_W-1:0] round_num_d;
    logic               last_round_s;

    assign last_round_s = (round_num_q == LAST_ROUND);

    // State and round counter registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            round_num_q <= ROUND_ZERO;
        end else begin
            state_q     <= state_d;
            round_num_q <= round_num_d;
        end
    end

    // Next-state and round-count logic; abort overrides every transition
    always_comb begin
        state_d     = state_q;
        round_num_d = round_num_q;
        if (abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            round_num_d = ROUND_ZERO;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
                LOAD: begin
                    round_num_d = ROUND_ZERO;
                    state_d     = ARK;
                end
                ARK: begin
                    if (!key_ready) begin
                        state_d = ARK;
                    end else if (last_round_s) begin
                        state_d = DONE;
                    end else begin
                        round_num_d = round_num_q + ROUND_ONE;
                        state_d     = SUB;
                    end
                end
                SUB:   state_d = SHIFT;
                SHIFT: begin
                    // Final round has no MixColumns
                    if (last_round_s) begin
                        state_d = ARK;
                    end else begin
                        state_d = MIX;
                    end
                end
                MIX:   state_d = ARK;
                DONE: begin
                    state_d     = IDLE;
                    round_num_d = ROUND_ZERO;
                end
                default: begin
                    state_d     = IDLE;
                    round_num_d = ROUND_ZERO;
                end
            endcase
        end
    end

    // Moore output decode; do_ark alone is gated by key_ready
    always_comb begin
        busy       = 1'b1;
        done       = 1'b0;
        load_state = 1'b0;
        do_sub     = 1'b0;
        do_shift   = 1'b0;
        do_mix     = 1'b0;
        do_ark     = 1'b0;
        key_req    = 1'b0;
        key_round  = ROUND_ZERO;
        case (state_q)
            IDLE:  busy       = 1'b0;
            LOAD:  load_state = 1'b1;
            SUB:   do_sub     = 1'b1;
            SHIFT: do_shift   = 1'b1;
            MIX:   do_mix     = 1'b1;
            ARK: begin
                key_req   = 1'b1;
                key_round = round_num_q;
                do_ark    = key_ready;
            end
            DONE:  done       = 1'b1;
            default: busy     = 1'b0;
        endcase
    end

    assign round_num = round_num_q;

endmodule

// File: tb/tb_aes_round_controller.sv
// Randomized bench for aes_round_controller: each cycle is checked against a
// flattened step schedule of one encryption derived from the round rules.
module tb_aes_round_controller;

    localparam int N  = 10;
    localparam int RW = 4;

    localparam int K_LOAD  = 0;
    localparam int K_SUB   = 1;
    localparam int K_SHIFT = 2;
    localparam int K_MIX   = 3;
    localparam int K_ARK   = 4;
    localparam int K_DONE  = 5;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          start;
    logic          abort;
    logic          key_ready;
    logic          busy;
    logic          done;
    logic          load_state;
    logic          do_sub;
    logic          do_shift;
    logic          do_mix;
    logic          do_ark;
    logic          key_req;
    logic [RW-1:0] key_round;
    logic [RW-1:0] round_num;

    int vectors     = 0;
    int miscompares = 0;
    int sk [0:63];
    int sr [0:63];
    int sched_len   = 0;

    aes_round_controller #(.NUM_ROUNDS(N), .ROUND_W(RW)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .abort      (abort),
        .key_ready  (key_ready),
        .busy       (busy),
        .done       (done),
        .load_state (load_state),
        .do_sub     (do_sub),
        .do_shift   (do_shift),
        .do_mix     (do_mix),
        .do_ark     (do_ark),
        .key_req    (key_req),
        .key_round  (key_round),
        .round_num  (round_num)
    );

    always #5 clk = ~clk;

    // One encryption as a list of datapath steps with the round each belongs to
    function automatic void build_schedule();
        int n = 0;
        sk[n] = K_LOAD; sr[n] = 0; n++;
        sk[n] = K_ARK;  sr[n] = 0; n++;
        for (int r = 1; r <= N; r++) begin
            sk[n] = K_SUB;   sr[n] = r; n++;
            sk[n] = K_SHIFT; sr[n] = r; n++;
            if (r < N) begin
                sk[n] = K_MIX; sr[n] = r; n++;
            end
            sk[n] = K_ARK; sr[n] = r; n++;
        end
        sk[n] = K_DONE; sr[n] = N; n++;
        sched_len = n;
    endfunction

    // kr_mode: 0 key always ready, 1 three-cycle stall at round-4 ARK, 2 random
    task automatic run_op(input int kr_mode, input int abort_cyc, input bit hold_start,
                          output int done_cyc, output int n_mix, output int n_ark,
                          output int n_done);
        int         idx = 0;
        int         stalls = 0;
        int         kind;
        int         rnd;
        bit         kr;
        bit         ab;
        logic [7:0] exp_f;
        logic [7:0] obs_f;
        done_cyc = 0; n_mix = 0; n_ark = 0; n_done = 0;
        @(negedge clk);
        start = 1'b1; abort = 1'b0; key_ready = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 400 && idx >= 0; cyc++) begin
            @(negedge clk);
            kind = sk[idx];
            rnd  = sr[idx];
            case (kr_mode)
                0:       kr = 1'b1;
                1:       kr = !(kind == K_ARK && rnd == 4 && stalls < 3);
                default: kr = ($urandom_range(0, 3) != 0);
            endcase
            ab = (cyc == abort_cyc);
            start = hold_start; key_ready = kr; abort = ab;
            #1;
            exp_f = {1'b1, kind == K_DONE, kind == K_LOAD, kind == K_SUB, kind == K_SHIFT,
                     kind == K_MIX, (kind == K_ARK) && kr, kind == K_ARK};
            obs_f = {busy, done, load_state, do_sub, do_shift, do_mix, do_ark, key_req};
            vectors++;
            if (obs_f !== exp_f || round_num !== RW'(rnd)) begin
                miscompares++;
                $display("FAIL cycle_outputs cyc=%0d step=%0d: flags=%b round=%0d, required flags=%b round=%0d",
                         cyc, idx, obs_f, round_num, exp_f, rnd);
            end
            if (kind == K_ARK) begin
                vectors++;
                if (key_round !== RW'(rnd)) begin
                    miscompares++;
                    $display("FAIL key_round cyc=%0d: got %0d, required %0d", cyc, key_round, rnd);
                end
            end
            if (do_mix === 1'b1) n_mix++;
            if (do_ark === 1'b1) n_ark++;
            if (done === 1'b1) begin
                n_done++;
                done_cyc = cyc;
            end
            @(posedge clk);
            if (ab) idx = -1;
            else if (kind == K_ARK && !kr) stalls++;
            else if (kind == K_DONE) idx = -1;
            else idx++;
        end
        vectors++;
        if (idx >= 0) begin
            miscompares++;
            $display("FAIL run_timeout: step %0d still pending, required completion", idx);
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0; key_ready = 1'b1;
        #1;
        obs_f = {busy, done, load_state, do_sub, do_shift, do_mix, do_ark, key_req};
        vectors++;
        if (obs_f !== 8'h00 || round_num !== {RW{1'b0}}) begin
            miscompares++;
            $display("FAIL post_idle: flags=%b round=%0d, required flags=00000000 round=0",
                     obs_f, round_num);
        end
    endtask

    task automatic test_reset();
        logic [7:0] obs_f;
        n_rst = 1'b0; start = 1'b0; abort = 1'b0; key_ready = 1'b0;
        #12;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) n_rst = 1'b1;
            @(negedge clk);
            #1;
            obs_f = {busy, done, load_state, do_sub, do_shift, do_mix, do_ark, key_req};
            vectors++;
            if (obs_f !== 8'h00 || round_num !== {RW{1'b0}} || key_round !== {RW{1'b0}}) begin
                miscompares++;
                $display("FAIL reset_idle i=%0d: flags=%b round=%0d key_round=%0d, required all 0",
                         i, obs_f, round_num, key_round);
            end
        end
    endtask

    task automatic test_nominal();
        int dc, nm, na, nd;
        run_op(0, -1, 1'b0, dc, nm, na, nd);
        vectors++;
        if (dc !== 42 || nm !== N - 1 || na !== N + 1 || nd !== 1) begin
            miscompares++;
            $display("FAIL nominal_counts: done_cyc=%0d mix=%0d ark=%0d done=%0d, required 42 %0d %0d 1",
                     dc, nm, na, nd, N - 1, N + 1);
        end
    endtask

    task automatic test_key_stall();
        int dc, nm, na, nd;
        run_op(1, -1, 1'b0, dc, nm, na, nd);
        vectors++;
        if (dc !== 45 || nd !== 1 || na !== N + 1) begin
            miscompares++;
            $display("FAIL key_stall: done_cyc=%0d done=%0d ark=%0d, required 45 1 %0d",
                     dc, nd, na, N + 1);
        end
    endtask

    task automatic test_abort();
        int dc, nm, na, nd;
        // cycle 25 is the MixColumns step of round 6
        run_op(0, 25, 1'b0, dc, nm, na, nd);
        vectors++;
        if (nd !== 0 || nm !== 6) begin
            miscompares++;
            $display("FAIL abort_mid: done=%0d mix=%0d, required 0 6", nd, nm);
        end
        run_op(0, -1, 1'b0, dc, nm, na, nd);
        vectors++;
        if (dc !== 42 || nd !== 1) begin
            miscompares++;
            $display("FAIL abort_rerun: done_cyc=%0d done=%0d, required 42 1", dc, nd);
        end
    endtask

    task automatic test_start_collision();
        int dc, nm, na, nd;
        run_op(0, -1, 1'b1, dc, nm, na, nd);
        vectors++;
        if (dc !== 42 || nd !== 1) begin
            miscompares++;
            $display("FAIL start_held: done_cyc=%0d done=%0d, required 42 1", dc, nd);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b1; abort = 1'b1;
            @(posedge clk);
            #1;
            vectors++;
            if (busy !== 1'b0 || load_state !== 1'b0) begin
                miscompares++;
                $display("FAIL start_abort_idle i=%0d: busy=%b load=%b, required 0 0",
                         i, busy, load_state);
            end
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic test_random();
        int dc, nm, na, nd, ac;
        for (int t = 0; t < 8; t++) begin
            ac = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 50));
            run_op(2, ac, 1'($urandom_range(0, 1)), dc, nm, na, nd);
            vectors++;
            if (nd > 1) begin
                miscompares++;
                $display("FAIL random_done_count t=%0d: got %0d, required at most 1", t, nd);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] obs_f;
        @(negedge clk);
        start = 1'b1; abort = 1'b0; key_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        // ten more edges land in cycle 11, the SubBytes step of round 3
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if (do_sub !== 1'b1 || round_num !== RW'(3)) begin
            miscompares++;
            $display("FAIL async_pre: sub=%b round=%0d, required 1 3", do_sub, round_num);
        end
        n_rst = 1'b0;
        #1;
        obs_f = {busy, done, load_state, do_sub, do_shift, do_mix, do_ark, key_req};
        vectors++;
        if (obs_f !== 8'h00 || round_num !== {RW{1'b0}} || key_round !== {RW{1'b0}}) begin
            miscompares++;
            $display("FAIL async_reset: flags=%b round=%0d, required all 0", obs_f, round_num);
        end
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || round_num !== {RW{1'b0}}) begin
            miscompares++;
            $display("FAIL async_release: busy=%b round=%0d, required 0 0", busy, round_num);
        end
    endtask

    initial begin
        build_schedule();
        test_reset();
        test_nominal();
        test_key_stall();
        test_abort();
        test_start_collision();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
